// File: rtl/rr_arbiter4.sv
// -----------------------------------------------------------------------------
// rr_arbiter4 -- four-requester round-robin arbiter with a per-grant hold limit.
//
// A requester keeps the resource for as long as it asserts its request. If it
// has held the resource for MAX_HOLD consecutive cycles while someone else is
// waiting, the grant is revoked and a one-cycle timeout pulse is raised. Every
// grant is followed by one dead cycle before the next arbitration. The search
// for the next winner starts just after the last granted index, which bounds
// the wait of any continuously requesting requester.
//
// Parameters
//   MAX_HOLD   consecutive grant cycles allowed while another request is
//              pending (2..255)
//   GNT_DELAY  simulation-only delay for grant updates; grants here update
//              with zero delay so simulation and synthesis agree
//
// Ports
//   clock      sole clock, all state changes on the rising edge
//   reset      synchronous, active-high
//   req[3:0]   request vector, bit i = requester i wants the resource
//   gnt[3:0]   registered grant, one-hot or all-zero
//   gnt_valid  registered, high exactly when gnt is nonzero
//   gnt_id     registered index of the granted requester (0 when idle)
//   timeout    registered one-cycle pulse when the hold limit revokes a grant
// -----------------------------------------------------------------------------
module rr_arbiter4 #(
  parameter int unsigned MAX_HOLD  = 8,
  parameter int unsigned GNT_DELAY = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic       gnt_valid,
  output logic [1:0] gnt_id,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GRANT   = 2'b01,
    HANDOFF = 2'b10
  } state_e;

  // hold_cnt saturates here; reaching it means MAX_HOLD cycles have elapsed.
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  // The grant delay is accepted so callers can keep their parameter lists,
  // but the register path is left undelayed.
  if (GNT_DELAY > 0) begin : g_gnt_delay_sim_only
  end

  state_e     state_q,     state_d;
  logic [1:0] owner_q,     owner_d;
  logic [1:0] last_q,      last_d;
  logic [7:0] hold_q,      hold_d;
  logic [3:0] gnt_q,       gnt_d;
  logic       gnt_valid_q, gnt_valid_d;
  logic [1:0] gnt_id_q,    gnt_id_d;
  logic       timeout_q,   timeout_d;

  // Rotating priority scan: candidate gi is last+gi+1 (mod 4), so candidate 3
  // wraps back onto last itself and the previous winner has lowest priority.
  logic [1:0] cand_idx [4];
  logic [3:0] cand_hit;
  logic [1:0] win_idx;
  logic [3:0] win_onehot;
  logic [3:0] owner_onehot;
  logic       any_req;
  logic       other_req;

  for (genvar gi = 0; gi < 4; gi++) begin : g_scan
    assign cand_idx[gi]     = last_q + 2'(gi + 1);
    assign cand_hit[gi]     = req[cand_idx[gi]];
    assign win_onehot[gi]   = (win_idx == 2'(gi));
    assign owner_onehot[gi] = (owner_q == 2'(gi));
  end

  always_comb begin
    win_idx = cand_idx[3];
    if (cand_hit[0]) begin
      win_idx = cand_idx[0];
    end else if (cand_hit[1]) begin
      win_idx = cand_idx[1];
    end else if (cand_hit[2]) begin
      win_idx = cand_idx[2];
    end
  end

  assign any_req   = |req;
  assign other_req = |(req & ~owner_onehot);

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    hold_d      = hold_q;
    gnt_d       = 4'b0000;
    gnt_valid_d = 1'b0;
    gnt_id_d    = 2'd0;
    timeout_d   = 1'b0;

    case (state_q)
      IDLE, HANDOFF: begin
        if (any_req) begin
          state_d     = GRANT;
          owner_d     = win_idx;
          last_d      = win_idx;
          hold_d      = 8'd0;
          gnt_d       = win_onehot;
          gnt_valid_d = 1'b1;
          gnt_id_d    = win_idx;
        end else begin
          state_d = IDLE;
        end
      end

      GRANT: begin
        if (!req[owner_q]) begin
          // Voluntary release wins over the hold limit: no timeout here.
          state_d = HANDOFF;
        end else if ((hold_q == HOLD_LAST) && other_req) begin
          state_d   = HANDOFF;
          timeout_d = 1'b1;
        end else begin
          // Keep the grant; a lone requester may sit at the limit forever.
          gnt_d       = gnt_q;
          gnt_valid_d = gnt_valid_q;
          gnt_id_d    = gnt_id_q;
          if (hold_q != HOLD_LAST) begin
            hold_d = hold_q + 8'd1;
          end
        end
      end

      default: begin
        // Corrupted encoding: recover to IDLE with every output low.
        state_d = IDLE;
        hold_d  = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= 2'd0;
      last_q      <= 2'd3;
      hold_q      <= 8'd0;
      gnt_q       <= 4'b0000;
      gnt_valid_q <= 1'b0;
      gnt_id_q    <= 2'd0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      hold_q      <= hold_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_id_q    <= gnt_id_d;
      timeout_q   <= timeout_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign gnt_id    = gnt_id_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// -----------------------------------------------------------------------------
// tb_rr_arbiter4 -- self-checking bench for rr_arbiter4.
//
// The reference model tracks who owns the resource and for how many cycles,
// and picks winners by walking indices after the last grant. Each scenario
// task drives req/reset at the falling edge, advances the model at the rising
// edge and compares the DUT outputs one time unit later.
// -----------------------------------------------------------------------------
module tb_rr_arbiter4;

  localparam int MAX_HOLD = 8;
  localparam int WAIT_MAX = 3 * (MAX_HOLD + 1);

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req   = 4'b0000;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_id;
  logic       timeout;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Model: owner (-1 when nobody holds the resource), cycles held so far,
  // last granted index and whether this edge revoked a grant by the limit.
  int m_owner = -1;
  int m_run   = 0;
  int m_last  = 3;
  bit m_to    = 1'b0;

  rr_arbiter4 #(.MAX_HOLD(MAX_HOLD), .GNT_DELAY(0)) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id),
    .timeout   (timeout)
  );

  always #5 clock = ~clock;

  task automatic model_edge(input logic [3:0] r, input logic rst);
    m_to = 1'b0;
    if (rst) begin
      m_owner = -1;
      m_run   = 0;
      m_last  = 3;
    end else if (m_owner >= 0) begin
      if (!r[m_owner]) begin
        m_owner = -1;
      end else if (m_run >= MAX_HOLD && (r & ~(4'b0001 << m_owner)) != 4'b0000) begin
        m_owner = -1;
        m_to    = 1'b1;
      end else begin
        m_run++;
      end
    end else begin
      for (int off = 1; off <= 4; off++) begin
        if (m_owner < 0 && r[(m_last + off) % 4]) begin
          m_owner = (m_last + off) % 4;
          m_last  = m_owner;
          m_run   = 1;
        end
      end
    end
  endtask

  function automatic logic [3:0] exp_gnt();
    return (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
  endfunction

  function automatic logic [1:0] exp_id();
    return (m_owner >= 0) ? 2'(m_owner) : 2'd0;
  endfunction

  function automatic logic exp_valid();
    return (m_owner >= 0);
  endfunction

  task automatic drive(input logic [3:0] r, input logic rst);
    @(negedge clock);
    req   = r;
    reset = rst;
    @(posedge clock);
    model_edge(r, rst);
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(4'b1111, 1'b1);
      $display("reset   cyc=%0d req=%b gnt=%b v=%b id=%0d to=%b", cyc, req, gnt, gnt_valid, gnt_id, timeout);
      checks++;
      if ({gnt, gnt_valid, gnt_id, timeout} !== 8'h00) begin
        errors++;
        $display("FAIL reset_outputs cyc=%0d got gnt=%b v=%b id=%0d to=%b want all zero", cyc, gnt, gnt_valid, gnt_id, timeout);
      end
    end
  endtask

  task automatic test_round_robin();
    int ids[$];
    int run_len;
    int exp_ids[5] = '{0, 1, 2, 3, 0};
    run_len = 0;
    drive(4'b0000, 1'b1);
    for (int i = 0; i < 46; i++) begin
      drive(4'b1111, 1'b0);
      $display("rr      cyc=%0d req=%b gnt=%b v=%b id=%0d to=%b", cyc, req, gnt, gnt_valid, gnt_id, timeout);
      checks++;
      if ({gnt, gnt_valid, gnt_id, timeout} !== {exp_gnt(), exp_valid(), exp_id(), m_to}) begin
        errors++;
        $display("FAIL rr_outputs cyc=%0d got %b/%b/%0d/%b want %b/%b/%0d/%b", cyc, gnt, gnt_valid, gnt_id, timeout, exp_gnt(), exp_valid(), exp_id(), m_to);
      end
      if (gnt_valid && run_len == 0) ids.push_back(int'(gnt_id));
      if (gnt_valid) begin
        run_len++;
      end else if (run_len != 0) begin
        checks++;
        if (run_len != MAX_HOLD || timeout !== 1'b1) begin
          errors++;
          $display("FAIL rr_hold_len cyc=%0d got len=%0d to=%b want len=%0d to=1", cyc, run_len, timeout, MAX_HOLD);
        end
        run_len = 0;
      end
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (k >= ids.size() || ids[k] != exp_ids[k]) begin
        errors++;
        $display("FAIL rr_order grant#%0d got %0d want %0d", k, (k < ids.size()) ? ids[k] : -1, exp_ids[k]);
      end
    end
  endtask

  // Applies a list of request vectors (reset first) and checks every cycle.
  task automatic run_seq(input string name, input logic [3:0] seq[$]);
    drive(4'b0000, 1'b1);
    foreach (seq[k]) begin
      drive(seq[k], 1'b0);
      $display("%-7s cyc=%0d req=%b gnt=%b v=%b id=%0d to=%b", name, cyc, req, gnt, gnt_valid, gnt_id, timeout);
      checks++;
      if ({gnt, gnt_valid, gnt_id, timeout} !== {exp_gnt(), exp_valid(), exp_id(), m_to}) begin
        errors++;
        $display("FAIL %s cyc=%0d got %b/%b/%0d/%b want %b/%b/%0d/%b", name, cyc, gnt, gnt_valid, gnt_id, timeout, exp_gnt(), exp_valid(), exp_id(), m_to);
      end
    end
  endtask

  task automatic test_single_release();
    logic [3:0] s[$] = '{4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
    run_seq("release", s);
  endtask

  task automatic test_hold_then_compete();
    logic [3:0] s[$];
    for (int i = 0; i < 20; i++) s.push_back(4'b0010);
    for (int i = 0; i < 4; i++) s.push_back(4'b1010);
    s.push_back(4'b1000);
    run_seq("compete", s);
    // After revocation and the dead cycle, requester 3 must own the grant.
    checks++;
    if (gnt !== 4'b1000) begin
      errors++;
      $display("FAIL compete_next got gnt=%b want 1000", gnt);
    end
  endtask

  task automatic test_release_beats_timeout();
    logic [3:0] s[$];
    for (int i = 0; i < MAX_HOLD; i++) s.push_back(4'b0010);
    for (int i = 0; i < 3; i++) s.push_back(4'b0100);
    run_seq("relprio", s);
    checks++;
    if (gnt !== 4'b0100 || gnt_id !== 2'd2) begin
      errors++;
      $display("FAIL relprio_next got gnt=%b id=%0d want 0100 id=2", gnt, gnt_id);
    end
  endtask

  task automatic test_reset_mid_grant();
    drive(4'b0000, 1'b1);
    drive(4'b0100, 1'b0);
    drive(4'b0100, 1'b0);
    drive(4'b0100, 1'b1);
    $display("rstmid  cyc=%0d req=%b gnt=%b v=%b id=%0d to=%b", cyc, req, gnt, gnt_valid, gnt_id, timeout);
    checks++;
    if ({gnt, gnt_valid, gnt_id, timeout} !== 8'h00) begin
      errors++;
      $display("FAIL rstmid_drop got %b/%b/%0d/%b want all zero", gnt, gnt_valid, gnt_id, timeout);
    end
    drive(4'b1100, 1'b0);
    $display("rstmid  cyc=%0d req=%b gnt=%b v=%b id=%0d to=%b", cyc, req, gnt, gnt_valid, gnt_id, timeout);
    checks++;
    if (gnt !== 4'b0100 || gnt_id !== 2'd2 || gnt_valid !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_regrant got gnt=%b id=%0d v=%b want 0100 id=2 v=1", gnt, gnt_id, gnt_valid);
    end
  endtask

  task automatic test_random();
    logic [3:0] r;
    int wait_cnt[4] = '{0, 0, 0, 0};
    int bad_before;
    bad_before = errors;
    r = 4'b0000;
    drive(4'b0000, 1'b1);
    for (int i = 0; i < 10000; i++) begin
      // Each bit flips rarely so requesters tend to stay up for a while.
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
      drive(r, 1'b0);
      checks++;
      if ({gnt, gnt_valid, gnt_id, timeout} !== {exp_gnt(), exp_valid(), exp_id(), m_to}) begin
        errors++;
        $display("FAIL rand_outputs cyc=%0d req=%b got %b/%b/%0d/%b want %b/%b/%0d/%b", cyc, r, gnt, gnt_valid, gnt_id, timeout, exp_gnt(), exp_valid(), exp_id(), m_to);
      end
      checks++;
      if ($countones(gnt) > 1 || gnt_valid !== (|gnt)) begin
        errors++;
        $display("FAIL rand_onehot cyc=%0d got gnt=%b v=%b want onehot/zero with v=|gnt", cyc, gnt, gnt_valid);
      end
      for (int b = 0; b < 4; b++) begin
        if (r[b] && !gnt[b]) wait_cnt[b]++;
        else wait_cnt[b] = 0;
        checks++;
        if (wait_cnt[b] > WAIT_MAX) begin
          errors++;
          $display("FAIL rand_wait cyc=%0d req%0d got wait=%0d want <=%0d", cyc, b, wait_cnt[b], WAIT_MAX);
          wait_cnt[b] = 0;
        end
      end
    end
    $display("random  cycles=10000 new_errors=%0d", errors - bad_before);
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_release();
    test_hold_then_compete();
    test_release_beats_timeout();
    test_reset_mid_grant();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_arbiter4.md
RR_ARBITER4 -- requirements
Module: rr_arbiter4

Interface
REQ-001 Parameter MAX_HOLD, default 8, maximum consecutive grant cycles to one requester while another requests; legal range 2..255.
REQ-002 Parameter GNT_DELAY, default 0, intra-assignment delay on grant-output register updates; simulation only, no effect on synthesized logic.
REQ-003 clock  input  1  sole clock; all state updates on posedge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req  input  4  request vector; bit i high = requester i wants the resource.
REQ-006 gnt  output  4  registered grant, one-hot or all-zero.
REQ-007 gnt_valid  output  1  registered, high exactly when gnt is nonzero.
REQ-008 gnt_id  output  2  registered index of granted requester; 0 when gnt_valid low.
REQ-009 timeout  output  1  registered one-cycle pulse when a grant is revoked by the hold limit.

Function
REQ-010 FSM states IDLE, GRANT, HANDOFF, binary- or one-hot-encoded; unreachable encodings SHALL return to IDLE on the next edge with all outputs low.
REQ-011 Internal state: owner (2 bits), last (2 bits, last granted index), hold_cnt (8 bits).
REQ-012 Arbitration: the winner is the first requesting index found scanning last+1, last+2, last+3, last+4 (mod 4).
REQ-013 IDLE, req==0: stay in IDLE; outputs low.
REQ-014 IDLE, req!=0 at edge k: at edge k, gnt = one-hot(winner), gnt_id = winner, gnt_valid = 1, owner = last = winner, hold_cnt = 0, state = GRANT. Request-to-grant latency is one edge.
REQ-015 GRANT: hold_cnt increments by 1 per edge, saturating at MAX_HOLD-1.
REQ-016 GRANT, req[owner]==0 at an edge: gnt, gnt_valid and gnt_id clear at that edge; state = HANDOFF; timeout stays 0.
REQ-017 GRANT, req[owner]==1, hold_cnt==MAX_HOLD-1, and another bit of req high: grant clears; timeout = 1 for one cycle; state = HANDOFF.
REQ-018 GRANT, req[owner]==1, hold_cnt==MAX_HOLD-1, no other request: keep the grant indefinitely with no timeout; a later competing request causes revocation at the next edge per REQ-017.
REQ-019 HANDOFF lasts exactly one cycle with outputs low (dead cycle); at its exit edge the block arbitrates as in REQ-013/REQ-014 using the updated last.
REQ-020 Owner release (REQ-016) takes precedence over timeout (REQ-017) at the same edge; timeout stays 0.
REQ-021 Requests from non-owners during GRANT SHALL NOT change the grant.
REQ-022 At most one gnt bit is high in any cycle; gnt_valid == |gnt at all times.
REQ-023 Worst-case wait for a continuously requesting requester: 3*(MAX_HOLD+1) cycles.

Reset
REQ-024 reset high at an edge: state = IDLE, gnt = 0, gnt_valid = 0, gnt_id = 0, timeout = 0, hold_cnt = 0, last = 3, overriding all other transitions.
REQ-025 Reset asserted mid-GRANT drops the grant at that same edge; the first grant after reset release goes to the lowest-index requester (last = 3).
REQ-026 Until the first clock edge with reset high, outputs are unspecified.

Verification
REQ-027 Reset, then req=4'b1111 held, MAX_HOLD=8 -> grants 0,1,2,3,0 in order; each grant lasts 8 cycles, then timeout pulse, then 1 dead cycle.
REQ-028 Reset, req=4'b0100 for 3 cycles then 0 -> gnt=4'b0100 one edge after req rises, held 3 cycles, cleared on the edge req is seen low, timeout never asserted.
REQ-029 req=4'b0010 only for 20 cycles -> gnt=4'b0010 throughout, no timeout; then raise req[3] -> grant revoked at the next edge with timeout=1, gnt=4'b1000 after the dead cycle.
REQ-030 During grant to 1 with hold_cnt=MAX_HOLD-1, drop req[1] while req[2] is high -> grant clears, timeout=0, next grant to 2.
REQ-031 Assert reset during grant to 2 -> all outputs 0 at that edge; release with req=4'b1100 -> grant to 2.
REQ-032 Random req for 10000 cycles -> one-hot/zero gnt every cycle, gnt_valid==|gnt, no requester waits beyond REQ-023.
